// File: rtl/instruction_fetch_pkg.sv
// Shared control types for the fetch sequencer and the memory block it drives.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 8
`endif

package instruction_fetch_pkg;

    localparam int ADDR_W = `ADDR_BUS_WIDTH;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        NOP      = 3'd0,
        READ     = 3'd1,
        WRITE    = 3'd2,
        INC      = 3'd3,
        ABSOLUTE = 3'd4,
        REL_ADD  = 3'd5,
        REL_SUB  = 3'd6
    } memory_op_e;

    typedef enum logic {
        PC  = 1'b0,
        MAR = 1'b1
    } memory_bus_selector_e;

    typedef enum logic [2:0] {
        IDLE,
        RD0_ISSUE,
        RD0_CAPT,
        RD1_ISSUE,
        RD1_CAPT,
        PC_INC,
        HOLD,
        BRANCH
    } fetch_state_e;

    // Only PC-modifying ops may reach memory from a branch request.
    function automatic memory_op_e legal_branch_op(input memory_op_e kind);
        case (kind)
            ABSOLUTE, REL_ADD, REL_SUB: return kind;
            default:                    return NOP;
        endcase
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads the two-word instruction at the memory PC, advances
// the PC, holds the instruction for the decoder and applies branch requests.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [DATA_W-1:0]           instr_opcode,
    output logic [DATA_W-1:0]           instr_operand,
    input  logic                        branch_valid,
    input  memory_op_e                  branch_kind,
    input  logic [DATA_W-1:0]           branch_value,
    output logic                        branch_ack,
    output memory_op_e                  mem_op,
    output memory_bus_selector_e        mem_bus_selector,
    output logic                        mem_data_word_selector,
    output logic [DATA_W-1:0]           mem_in,
    input  logic [DATA_W-1:0]           mem_out
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    memory_op_e        br_op_q, br_op_d;
    logic [DATA_W-1:0] br_val_q, br_val_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            br_op_q   <= NOP;
            br_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            br_op_q   <= br_op_d;
            br_val_q  <= br_val_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        br_op_d   = br_op_q;
        br_val_d  = br_val_q;
        case (state_q)
            IDLE: begin
                if (branch_valid) begin
                    state_d  = BRANCH;
                    br_op_d  = legal_branch_op(branch_kind);
                    br_val_d = branch_value;
                end else if (run) begin
                    state_d = RD0_ISSUE;
                end
            end
            RD0_ISSUE: state_d = RD0_CAPT;
            // mem_out now carries the word registered during the issue cycle
            RD0_CAPT: begin
                opcode_d = mem_out;
                state_d  = RD1_ISSUE;
            end
            RD1_ISSUE: state_d = RD1_CAPT;
            RD1_CAPT: begin
                operand_d = mem_out;
                state_d   = PC_INC;
            end
            PC_INC: state_d = HOLD;
            HOLD: begin
                if (branch_valid) begin
                    state_d  = BRANCH;
                    br_op_d  = legal_branch_op(branch_kind);
                    br_val_d = branch_value;
                end else if (instr_ready) begin
                    state_d = run ? RD0_ISSUE : IDLE;
                end
            end
            BRANCH:  state_d = run ? RD0_ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory drive is decoded purely from registered state.
    always_comb begin
        mem_op                 = NOP;
        mem_data_word_selector = 1'b0;
        mem_in                 = '0;
        case (state_q)
            RD0_ISSUE, RD0_CAPT: mem_op = READ;
            RD1_ISSUE, RD1_CAPT: begin
                mem_op                 = READ;
                mem_data_word_selector = 1'b1;
            end
            PC_INC: mem_op = INC;
            BRANCH: begin
                mem_op = br_op_q;
                mem_in = br_val_q;
            end
            default: mem_op = NOP;
        endcase
    end

    assign mem_bus_selector = PC;
    assign instr_valid      = (state_q == HOLD);
    assign branch_ack       = (state_q == BRANCH);
    assign instr_opcode     = opcode_q;
    assign instr_operand    = operand_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a behavioural memory block attached.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int NCELLS = 2 ** (ADDR_W + 1);

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 run;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [7:0]           instr_opcode;
    logic [7:0]           instr_operand;
    logic                 branch_valid;
    memory_op_e           branch_kind;
    logic [7:0]           branch_value;
    logic                 branch_ack;
    memory_op_e           mem_op;
    memory_bus_selector_e mem_bus_selector;
    logic                 mem_data_word_selector;
    logic [7:0]           mem_in;
    logic [7:0]           mem_out;

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clock                  (clock),
        .reset                  (reset),
        .run                    (run),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .instr_opcode           (instr_opcode),
        .instr_operand          (instr_operand),
        .branch_valid           (branch_valid),
        .branch_kind            (branch_kind),
        .branch_value           (branch_value),
        .branch_ack             (branch_ack),
        .mem_op                 (mem_op),
        .mem_bus_selector       (mem_bus_selector),
        .mem_data_word_selector (mem_data_word_selector),
        .mem_in                 (mem_in),
        .mem_out                (mem_out)
    );

    always #5 clock = ~clock;

    // Memory model: PC addresses instruction pairs, cell = {pc, word_sel}.
    logic [7:0]        cells [0:NCELLS-1];
    logic [ADDR_W-1:0] mem_pc;
    int                reads = 0;

    always @(posedge clock) begin
        if (reset) begin
            mem_pc  <= '0;
            mem_out <= '0;
        end else begin
            case (mem_op)
                READ: begin
                    mem_out <= cells[{mem_pc, mem_data_word_selector}];
                    reads   <= reads + 1;
                end
                INC:      mem_pc <= mem_pc + 1'b1;
                ABSOLUTE: mem_pc <= ADDR_W'(mem_in);
                REL_ADD:  mem_pc <= mem_pc + ADDR_W'(mem_in);
                REL_SUB:  mem_pc <= mem_pc - ADDR_W'(mem_in);
                default:  ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s: instr_valid got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Scoreboard: expected instructions queued by the driver, popped on hand-off.
    typedef struct {
        logic [7:0] opc;
        logic [7:0] opr;
    } instr_t;
    instr_t exp_q[$];

    always @(negedge clock) begin
        instr_t e;
        if (!reset && instr_valid && instr_ready && !branch_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handoff_unexpected: got opcode 0x%0h with empty queue, expected none",
                         instr_opcode);
            end else begin
                e = exp_q.pop_front();
                check("handoff_opcode", 32'(instr_opcode), 32'(e.opc));
                check("handoff_operand", 32'(instr_operand), 32'(e.opr));
            end
        end
    end

    typedef struct {
        memory_op_e op;
        logic       ws;
        logic       valid;
    } lat_t;
    lat_t lat_tbl [6];

    typedef struct {
        memory_op_e kind;
        logic [7:0] value;
        memory_op_e exp_op;
        logic [7:0] exp_pc;
        logic [7:0] exp_opc;
        logic [7:0] exp_opr;
    } br_t;
    br_t br_tbl [5];

    initial begin
        int rd_before;

        lat_tbl[0] = '{READ, 1'b0, 1'b0};
        lat_tbl[1] = '{READ, 1'b0, 1'b0};
        lat_tbl[2] = '{READ, 1'b1, 1'b0};
        lat_tbl[3] = '{READ, 1'b1, 1'b0};
        lat_tbl[4] = '{INC,  1'b0, 1'b0};
        lat_tbl[5] = '{NOP,  1'b0, 1'b1};

        br_tbl[0] = '{ABSOLUTE, 8'h10, ABSOLUTE, 8'h10, 8'h7A, 8'h7B};
        br_tbl[1] = '{ABSOLUTE, 8'h04, ABSOLUTE, 8'h04, 8'h52, 8'h53};
        br_tbl[2] = '{REL_SUB,  8'h03, REL_SUB,  8'h02, 8'h5E, 8'h5F};
        br_tbl[3] = '{REL_ADD,  8'h0C, REL_ADD,  8'h0F, 8'h44, 8'h45};
        br_tbl[4] = '{READ,     8'h33, NOP,      8'h10, 8'h7A, 8'h7B};

        for (int i = 0; i < NCELLS; i++) cells[i] = 8'(i) ^ 8'h5A;
        cells[0] = 8'hA5;
        cells[1] = 8'h3C;

        reset = 1'b1; run = 1'b1; instr_ready = 1'b0;
        branch_valid = 1'b0; branch_kind = NOP; branch_value = 8'h00;
        repeat (3) step();

        // Reset values, with run asserted to show reset priority
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_opcode", 32'(instr_opcode), 32'd0);
        check("rst_operand", 32'(instr_operand), 32'd0);
        check("rst_ack", 32'(branch_ack), 32'd0);
        check("rst_mem_op", 32'(mem_op), 32'(NOP));
        check("rst_bus_sel", 32'(mem_bus_selector), 32'(PC));
        check("rst_word_sel", 32'(mem_data_word_selector), 32'd0);
        check("rst_mem_in", 32'(mem_in), 32'd0);

        reset = 1'b0; run = 1'b0;
        step();
        check("idle_mem_op", 32'(mem_op), 32'(NOP));

        // Basic fetch with per-cycle memory drive
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("lat%0d_op", k), 32'(mem_op), 32'(lat_tbl[k].op));
            check($sformatf("lat%0d_ws", k), 32'(mem_data_word_selector), 32'(lat_tbl[k].ws));
            check($sformatf("lat%0d_valid", k), 32'(instr_valid), 32'(lat_tbl[k].valid));
            check($sformatf("lat%0d_mem_in", k), 32'(mem_in), 32'd0);
        end
        check("basic_opcode", 32'(instr_opcode), 32'hA5);
        check("basic_operand", 32'(instr_operand), 32'h3C);
        check("basic_pc", 32'(mem_pc), 32'd1);

        // Backpressure
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_opcode", 32'(instr_opcode), 32'hA5);
            check("bp_operand", 32'(instr_operand), 32'h3C);
            check("bp_mem_op", 32'(mem_op), 32'(NOP));
            check("bp_pc", 32'(mem_pc), 32'd1);
        end
        exp_q.push_back('{8'hA5, 8'h3C});
        instr_ready = 1'b1;
        step();
        check("bp_restart_op", 32'(mem_op), 32'(READ));
        check("bp_restart_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;
        wait_valid("second_fetch");
        check("second_opcode", 32'(instr_opcode), 32'h58);
        check("second_operand", 32'(instr_operand), 32'h59);
        check("second_pc", 32'(mem_pc), 32'd2);

        // Branches issued from HOLD; each drops the held instruction
        for (int i = 0; i < 5; i++) begin
            branch_kind  = br_tbl[i].kind;
            branch_value = br_tbl[i].value;
            branch_valid = 1'b1;
            step();
            check($sformatf("br%0d_ack", i), 32'(branch_ack), 32'd1);
            check($sformatf("br%0d_mem_op", i), 32'(mem_op), 32'(br_tbl[i].exp_op));
            check($sformatf("br%0d_mem_in", i), 32'(mem_in), 32'(br_tbl[i].value));
            check($sformatf("br%0d_valid", i), 32'(instr_valid), 32'd0);
            branch_valid = 1'b0;
            step();
            check($sformatf("br%0d_pc", i), 32'(mem_pc), 32'(br_tbl[i].exp_pc));
            check($sformatf("br%0d_ack_fall", i), 32'(branch_ack), 32'd0);
            check($sformatf("br%0d_in_zero", i), 32'(mem_in), 32'd0);
            wait_valid($sformatf("br%0d_refetch", i));
            check($sformatf("br%0d_opcode", i), 32'(instr_opcode), 32'(br_tbl[i].exp_opc));
            check($sformatf("br%0d_operand", i), 32'(instr_operand), 32'(br_tbl[i].exp_opr));
            check($sformatf("br%0d_pc_inc", i), 32'(mem_pc), 32'(8'(br_tbl[i].exp_pc + 8'd1)));
        end

        // run falls mid-fetch: fetch completes, then the unit idles
        exp_q.push_back('{8'h7A, 8'h7B});
        instr_ready = 1'b1;
        step();
        check("stop_fetch_op", 32'(mem_op), 32'(READ));
        run = 1'b0; instr_ready = 1'b0;
        wait_valid("stop_fetch");
        check("stop_opcode", 32'(instr_opcode), 32'h78);
        check("stop_operand", 32'(instr_operand), 32'h79);
        check("stop_pc", 32'(mem_pc), 32'h12);
        exp_q.push_back('{8'h78, 8'h79});
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("stop_valid", 32'(instr_valid), 32'd0);
        rd_before = reads;
        for (int k = 0; k < 5; k++) begin
            check("stop_idle_op", 32'(mem_op), 32'(NOP));
            step();
        end
        check("stop_no_reads", 32'(reads), 32'(rd_before));
        check("stop_pc_hold", 32'(mem_pc), 32'h12);

        // Branch from IDLE with run low returns to IDLE
        branch_kind = ABSOLUTE; branch_value = 8'h00; branch_valid = 1'b1;
        step();
        check("idle_br_ack", 32'(branch_ack), 32'd1);
        check("idle_br_op", 32'(mem_op), 32'(ABSOLUTE));
        branch_valid = 1'b0;
        step();
        check("idle_br_back_op", 32'(mem_op), 32'(NOP));
        check("idle_br_pc", 32'(mem_pc), 32'd0);
        run = 1'b1;
        wait_valid("idle_br_fetch");
        check("idle_br_opcode", 32'(instr_opcode), 32'hA5);
        check("idle_br_operand", 32'(instr_operand), 32'h3C);

        // Reset during RD1_CAPT abandons the fetch
        exp_q.push_back('{8'hA5, 8'h3C});
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        step();
        step();
        check("rd1capt_op", 32'(mem_op), 32'(READ));
        check("rd1capt_ws", 32'(mem_data_word_selector), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_opcode", 32'(instr_opcode), 32'd0);
        check("mid_rst_operand", 32'(instr_operand), 32'd0);
        check("mid_rst_mem_op", 32'(mem_op), 32'(NOP));
        check("mid_rst_ws", 32'(mem_data_word_selector), 32'd0);
        check("mid_rst_ack", 32'(branch_ack), 32'd0);
        check("mid_rst_pc", 32'(mem_pc), 32'd0);
        reset = 1'b0; run = 1'b0;
        step();
        check("post_rst_op", 32'(mem_op), 32'(NOP));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch sequencer directly upstream of the memory block. It drives the memory control inputs: op, bus_selector, data_word_selector and in. Using the memory's program counter, it reads the two-word instruction (word 0 = opcode, word 1 = operand) and advances the PC. It holds the instruction for the decoder under a valid/ready handshake and applies branch requests to the PC through the memory's ABSOLUTE, REL_ADD and REL_SUB ops.

Parameters:
- None. Address width comes from the global `ADDR_BUS_WIDTH; the data width is fixed at 8.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = keep fetching, 0 = stop after the current hand-off
- instr_valid  out  1  opcode/operand hold a fetched instruction
- instr_ready  in  1  decoder accepts the instruction
- instr_opcode  out  8  word 0 of the instruction
- instr_operand  out  8  word 1 of the instruction
- branch_valid  in  1  branch request
- branch_kind  in  memory_op_e  ABSOLUTE, REL_ADD or REL_SUB
- branch_value  in  8  target or offset
- branch_ack  out  1  one-cycle pulse when the branch op is issued to memory
- mem_op  out  memory_op_e  to memory op
- mem_bus_selector  out  memory_bus_selector_e  to memory bus_selector
- mem_data_word_selector  out  1  to memory data_word_selector
- mem_in  out  8  to memory in
- mem_out  in  8  from memory out

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high (ports named clock and reset).
- All outputs are registered or decoded from the registered state only; there are no combinational input-to-output paths.
- Reset values:
  - state IDLE
  - instr_valid=0, instr_opcode=0, instr_operand=0, branch_ack=0
  - mem_op=NOP, mem_bus_selector=PC, mem_data_word_selector=0, mem_in=0
- Reset has priority over every other input. Reset mid-fetch abandons the fetch; state is IDLE on the next cycle.
- Memory read timing is fixed by the memory block. READ must be held for two consecutive cycles: the cycle after issue shows the registered data on mem_out.
- States and memory drive (bus_selector=PC in every active state):
  - IDLE: mem_op=NOP.
    - If branch_valid -> BRANCH.
    - Else if run -> RD0_ISSUE.
  - RD0_ISSUE: READ, word_sel=0 -> RD0_CAPT.
  - RD0_CAPT: READ, word_sel=0; mem_out is captured into instr_opcode at the clock edge -> RD1_ISSUE.
  - RD1_ISSUE: READ, word_sel=1 -> RD1_CAPT.
  - RD1_CAPT: READ, word_sel=1; mem_out is captured into instr_operand -> PC_INC.
  - PC_INC: INC -> HOLD.
  - HOLD: NOP, instr_valid=1, instruction registers stable. Transitions, in priority order:
    - branch_valid=1 -> BRANCH; the held instruction is dropped and instr_valid falls.
    - instr_ready=1 -> hand-off; then RD0_ISSUE if run=1, else IDLE.
    - Otherwise stay in HOLD.
  - BRANCH: mem_op=branch_kind, mem_in=branch_value (both latched on entry), branch_ack=1.
    - Then RD0_ISSUE if run=1, else IDLE.
    - A branch_kind outside {ABSOLUTE, REL_ADD, REL_SUB} is driven as NOP; the ack is still pulsed.
- branch_valid is sampled only in IDLE and HOLD and is ignored during RD*/PC_INC. The requester holds it until branch_ack.
- Latency: leaving IDLE at cycle 0, instr_valid=1 at cycle 5; hand-off-to-next-valid is 5 cycles.
- Relative branches apply to the already-incremented PC (address of the next instruction).
- PC wrap-around is the memory's modulo arithmetic; the fetch unit does not check it.
- mem_in is 0 in every state except BRANCH. The fetch unit never issues WRITE and never selects MAR.
- run falling mid-fetch does not abort; the fetch completes to HOLD.

Decomposition:
- The shared control package holds:
  - memory_op_e, with a NOP member at encoding 0 added if not present
  - memory_bus_selector_e
  - new fetch_state_e {IDLE, RD0_ISSUE, RD0_CAPT, RD1_ISSUE, RD1_CAPT, PC_INC, HOLD, BRANCH}
- Single module with no sub-module. The bench instantiates it with the memory block.

Test Plan:
- Basic fetch: cells[0]=0xA5, cells[1]=0x3C, run=1, ready=1 -> valid at cycle 5 with opcode 0xA5, operand 0x3C; memory PC=1 after PC_INC; the next fetch reads cells[2..3].
- Backpressure: ready=0 for 4 cycles in HOLD -> valid stays 1, opcode/operand unchanged, mem_op=NOP every cycle, PC unchanged; ready=1 -> next fetch starts the following cycle.
- Absolute branch in HOLD: ABSOLUTE with value 0x10 -> one BRANCH cycle with mem_op=ABSOLUTE, mem_in=0x10, ack=1; the instruction is dropped; the refetch reads cells[0x20..0x21].
- REL_SUB: PC=5, REL_SUB with value 3 -> PC=2, then fetch of cells[4..5]. An illegal kind (READ) gives mem_op=NOP with ack=1 and PC unchanged.
- Reset asserted during RD1_CAPT -> IDLE next cycle, all outputs at reset values, memory PC=0.
- run=0 during a fetch -> the fetch completes to HOLD; after hand-off the unit goes IDLE with mem_op=NOP, and no further reads occur until run=1.
